// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants for the IF stage of the 16-bit A/B accumulator pipeline.
// Mirrors the PC_W / NOP_INST / RESET_PC definitions used by the decoder side.
package inst_fetch_unit_pkg;

    localparam int unsigned DEF_PC_W   = 10;
    localparam int unsigned DEF_INST_W = 16;
    localparam int unsigned DEF_CNT_W  = 16;

    localparam logic [DEF_PC_W-1:0] DEF_RESET_PC = 10'h000;

    // NOP opcode occupies the bits above the 10-bit target field.
    localparam logic [DEF_INST_W-DEF_PC_W-1:0] OP_NOP = '0;
    localparam logic [DEF_INST_W-1:0] NOP_INST = {OP_NOP, {DEF_PC_W{1'b0}}};

endpackage

// File: rtl/inst_fetch_unit_pc_next_sel.sv
// Next-PC selection: branch beats jump, jump beats stall, otherwise sequential fetch.
// Purely combinational; the top registers everything.
module pc_next_sel
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W = DEF_PC_W
) (
    input  logic [PC_W-1:0] pc,
    input  logic            stall,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_target,
    input  logic            branch_en,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] pc_next,
    output logic            load_bubble,
    output logic            hold,
    output logic            redirect
);

    always_comb begin
        pc_next     = pc + PC_W'(1);
        load_bubble = 1'b0;
        hold        = 1'b0;
        redirect    = 1'b0;
        if (branch_en) begin
            pc_next     = branch_target;
            load_bubble = 1'b1;
            redirect    = 1'b1;
        end else if (jump_en && !stall) begin
            pc_next     = jump_target;
            load_bubble = 1'b1;
            redirect    = 1'b1;
        end else if (stall) begin
            // A jump seen under stall stays in ID and re-asserts later.
            pc_next = pc;
            hold    = 1'b1;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// IF stage: PC register, IF/ID register and saturating fetch/flush counters.
// ROM is read combinationally at rom_addr = pc and captured one edge later.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned     PC_W     = DEF_PC_W,
    parameter int unsigned     INST_W   = DEF_INST_W,
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter int unsigned     CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              jump_en,
    input  logic [PC_W-1:0]   jump_target,
    input  logic              branch_en,
    input  logic [PC_W-1:0]   branch_target,
    output logic [PC_W-1:0]   rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic [INST_W-1:0] if_id_inst,
    output logic [PC_W-1:0]   if_id_pc,
    output logic              if_id_valid,
    output logic [CNT_W-1:0]  fetch_count,
    output logic [CNT_W-1:0]  flush_count
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic            load_bubble;
    logic            hold;
    logic            redirect;

    pc_next_sel #(.PC_W(PC_W)) u_pc_next_sel (
        .pc            (pc),
        .stall         (stall),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .pc_next       (pc_next),
        .load_bubble   (load_bubble),
        .hold          (hold),
        .redirect      (redirect)
    );

    assign rom_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_id_inst  <= INST_W'(NOP_INST);
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            pc <= pc_next;
            if (load_bubble) begin
                if_id_inst  <= INST_W'(NOP_INST);
                if_id_pc    <= '0;
                if_id_valid <= 1'b0;
            end else if (!hold) begin
                if_id_inst  <= rom_data;
                if_id_pc    <= pc;
                if_id_valid <= 1'b1;
                if (fetch_count != '1)
                    fetch_count <= fetch_count + CNT_W'(1);
            end
            // Counters stick at all-ones rather than wrapping.
            if (redirect && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: stimulus queues hand-computed IF/ID state,
// a monitor compares it one step after each rising edge.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        jump_en = 1'b0;
    logic [9:0]  jump_target = '0;
    logic        branch_en = 1'b0;
    logic [9:0]  branch_target = '0;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] if_id_inst;
    logic [9:0]  if_id_pc;
    logic        if_id_valid;
    logic [15:0] fetch_count;
    logic [15:0] flush_count;

    typedef struct {
        logic [15:0] inst;
        logic [9:0]  pc;
        logic        valid;
        logic [9:0]  addr;
        logic [15:0] fc;
        logic [15:0] flc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   stim_done = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .if_id_inst    (if_id_inst),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .fetch_count   (fetch_count),
        .flush_count   (flush_count)
    );

    // ROM contents: two fixed words at 0/1, elsewhere 16'hA000 | addr.
    always_comb begin
        if (rom_addr == 10'd0)      rom_data = 16'h1234;
        else if (rom_addr == 10'd1) rom_data = 16'h5678;
        else                        rom_data = 16'hA000 | {6'b0, rom_addr};
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("if_id_inst",  if_id_inst,          e.inst);
            check("if_id_pc",    {6'b0, if_id_pc},    {6'b0, e.pc});
            check("if_id_valid", {15'b0, if_id_valid}, {15'b0, e.valid});
            check("rom_addr",    {6'b0, rom_addr},    {6'b0, e.addr});
            check("fetch_count", fetch_count,         e.fc);
            check("flush_count", flush_count,         e.flc);
        end
    end

    // Drive one edge's inputs; optionally queue the state expected after that edge.
    task automatic step(input logic rst, input logic st, input logic je, input logic [9:0] jt,
                        input logic be, input logic [9:0] bt, input bit chk,
                        input logic [15:0] inst, input logic [9:0] ipc, input logic v,
                        input logic [9:0] addr, input logic [15:0] fc, input logic [15:0] flc);
        exp_t e;
        @(negedge clk);
        reset = rst; stall = st; jump_en = je; jump_target = jt;
        branch_en = be; branch_target = bt;
        if (chk) begin
            e.inst = inst; e.pc = ipc; e.valid = v; e.addr = addr; e.fc = fc; e.flc = flc;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        // 1: reset for two edges, then sequential fetch
        step(1, 0, 0, 0, 0, 0, 1, 16'h0000, 10'h000, 0, 10'h000, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 16'h0000, 10'h000, 0, 10'h000, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 16'h1234, 10'h000, 1, 10'h001, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 16'h5678, 10'h001, 1, 10'h002, 2, 0);
        step(0, 0, 0, 0, 0, 0, 1, 16'hA002, 10'h002, 1, 10'h003, 3, 0);
        step(0, 0, 0, 0, 0, 0, 1, 16'hA003, 10'h003, 1, 10'h004, 4, 0);
        step(0, 0, 0, 0, 0, 0, 1, 16'hA004, 10'h004, 1, 10'h005, 5, 0);
        // 2: stall three edges at pc=5, then release
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 0, 0, 0, 1, 16'hA004, 10'h004, 1, 10'h005, 5, 0);
        step(0, 0, 0, 0, 0, 0, 1, 16'hA005, 10'h005, 1, 10'h006, 6, 0);
        // 3: jump to 0x040
        step(0, 0, 1, 10'h040, 0, 0, 1, 16'h0000, 10'h000, 0, 10'h040, 6, 1);
        step(0, 0, 0, 0, 0, 0, 1, 16'hA040, 10'h040, 1, 10'h041, 7, 1);
        // 4: branch beats stall and jump
        step(0, 1, 1, 10'h040, 1, 10'h100, 1, 16'h0000, 10'h000, 0, 10'h100, 7, 2);
        step(0, 0, 0, 0, 0, 0, 1, 16'hA100, 10'h100, 1, 10'h101, 8, 2);
        // 5: jump under stall holds, then redirects
        step(0, 1, 1, 10'h200, 0, 0, 1, 16'hA100, 10'h100, 1, 10'h101, 8, 2);
        step(0, 0, 1, 10'h200, 0, 0, 1, 16'h0000, 10'h000, 0, 10'h200, 8, 3);
        step(0, 0, 0, 0, 0, 0, 1, 16'hA200, 10'h200, 1, 10'h201, 9, 3);
        // 6: PC wrap at 0x3FF
        step(0, 0, 1, 10'h3FF, 0, 0, 1, 16'h0000, 10'h000, 0, 10'h3FF, 9, 4);
        step(0, 0, 0, 0, 0, 0, 1, 16'hA3FF, 10'h3FF, 1, 10'h000, 10, 4);
        step(0, 0, 0, 0, 0, 0, 1, 16'h1234, 10'h000, 1, 10'h001, 11, 4);
        // 70000 unchecked fetches from pc=1 leave pc=0x171 and fetch_count saturated
        for (int i = 0; i < 70000; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 16'hA171, 10'h171, 1, 10'h172, 16'hFFFF, 4);
        // reset mid-stall/mid-branch wins outright
        step(1, 1, 1, 10'h040, 1, 10'h100, 1, 16'h0000, 10'h000, 0, 10'h000, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 16'h1234, 10'h000, 1, 10'h001, 1, 0);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        if (!stim_done) begin
            $display("FAIL watchdog: stimulus not complete at %0t, expected completion", $time);
            $fatal(1, "watchdog expired");
        end
    end

endmodule
